wb_arb_ysyx_23060136: RTL and testbench
=======================================

# wb_arb_ysyx_23060136

Write-port arbiter and long-latency scoreboard for the GPR register-file write port. It shares the single GPR write port between the in-order pipeline write-back bus and a long-latency unit (LLU, e.g. multiply/divide). LLU results are buffered in a small FIFO and written when the pipeline slot is free. A starvation guard stalls the pipeline for one cycle when the LLU has waited too long. A pending-rd scoreboard tells the hazard unit which registers still await an LLU result.

## Interface
- FIFO_DEPTH, 2, LLU result buffer entries (power of two, ≥2)
- STARVE_MAX, 4, cycles an LLU head entry may wait before a stall is forced (≥1)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p_i_commit  in  1  pipeline WB slot valid
- p_i_RegWr  in  1  pipeline requests GPR write
- p_i_rd  in  5  pipeline destination
- p_i_busW  in  32  pipeline write data
- l_i_issue  in  1  LLU accepted an op this cycle
- l_i_issue_rd  in  5  destination of issued op
- l_i_valid  in  1  LLU result valid
- l_i_rd  in  5  LLU result destination
- l_i_data  in  32  LLU result data
- l_o_ready  out  1  arbiter accepts LLU result
- q_i_rs1, q_i_rs2  in  5 each  hazard query addresses
- q_o_rs1_busy, q_o_rs2_busy  out  1 each  register awaits LLU result
- o_RegWr  out  1  GPR write enable
- o_rd  out  5  GPR write address
- o_busW  out  32  GPR write data
- o_src  out  1  0 = pipeline, 1 = LLU
- o_stall_req  out  1  pipeline must hold its WB inputs this cycle

## Operation
- preq = p_i_commit & p_i_RegWr & (p_i_rd != 0). Pipeline writes to x0 are dropped: o_RegWr = 0 for them, and the slot counts as free.
- FIFO push when l_i_valid & l_o_ready. l_o_ready = !full, computed from registered count only, so no push is accepted when the FIFO is full even in a pop cycle.
- An LLU result with l_i_rd = 0 is accepted (handshake completes) but not pushed.
- Grant priority, evaluated each cycle:
  1. o_stall_req = 1: pop the FIFO head. o_src = 1. Pipeline inputs are ignored and the pipeline re-presents them next cycle.
  2. preq: pipeline write. o_src = 0.
  3. FIFO non-empty: pop the head. o_src = 1.
  4. Otherwise o_RegWr = 0.
- No bypass from push to write. An entry pushed in cycle t is writable at t+1 at the earliest.
- starve_cnt (registered):
  - Cleared on pop or when the FIFO is empty.
  - Otherwise incremented, saturating at STARVE_MAX.
- o_stall_req = !empty & (starve_cnt == STARVE_MAX). It is therefore high for exactly one cycle per starvation event.
- Scoreboard pending[31:1]:
  - Set on l_i_issue with l_i_issue_rd != 0.
  - Cleared when an LLU write to that rd is granted.
  - If set and clear hit the same rd in one cycle, set wins.
  - At most one outstanding LLU op per rd; the issue controller enforces this via the busy query.
- q_o_rsX_busy = pending[q_i_rsX], read from the registered state. Always 0 for rs = 0. A register cleared in cycle t reads not-busy from t+1. The same-cycle value is available on o_busW for forwarding.
- Reset clears the FIFO, count, pointers, starve_cnt and pending. Buffered entries are discarded and never written.

## Timing
- Output path: o_RegWr/o_rd/o_busW/o_src/o_stall_req are combinational from the inputs and registered state, and drive the register file in the same cycle.
- LLU latency: l_i_valid accepted at t → earliest write at t+1.
- Starvation bound: the head entry is written no later than STARVE_MAX+1 cycles after it becomes head.
- While rst = 1: o_RegWr = 0, o_stall_req = 0, l_o_ready = 0, both busy outputs = 0.
- After rst deasserts: o_rd = 0, o_busW = 0, o_src = 0 when idle; l_o_ready = 1.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits with a separate count register. Full = (count == FIFO_DEPTH).

## Test plan
- Reset: hold rst 2 cycles, then release → l_o_ready = 1, o_RegWr = 0, o_stall_req = 0; query rs1 = 5 → busy = 0.
- Idle write: issue rd = 5, then l_i_valid with rd = 5, data = 0xDEADBEEF at t.
  - Between issue and write: q rs1 = 5 → busy = 1.
  - t+1: o_RegWr = 1, o_rd = 5, o_busW = 0xDEADBEEF, o_src = 1.
  - t+2: busy = 0.
- Starvation: pipeline writes rd = 3, 0x11 every cycle; push LLU rd = 7, 0x77 at t.
  - Pipeline wins t+1..t+4.
  - t+5: o_stall_req = 1, o_rd = 7, o_src = 1.
  - t+6: pipeline resumes.
- Full FIFO: pipeline writes every cycle, LLU presents 3 results back-to-back → first two accepted, then l_o_ready = 0 until the first stall-driven pop.
- x0 handling:
  - Pipeline rd = 0 with RegWr = 1 and FIFO non-empty → head written that cycle (o_src = 1).
  - LLU result rd = 0 → handshake completes, no write ever occurs.
- Reset mid-operation: FIFO holds 2 entries and pending[5], pending[9] are set; assert rst for 1 cycle → no LLU write in any later cycle; busy(5) = busy(9) = 0; l_o_ready = 1.

Source files
------------

// File: rtl/wb_arb_ysyx_23060136.sv
// wb_arb_ysyx_23060136
// GPR write-port arbiter with an LLU result buffer and a pending-rd scoreboard.
// The single register-file write port is shared between the in-order pipeline
// write-back slot and a long-latency unit (multiply/divide). LLU results wait in
// a small FIFO and are written whenever the pipeline slot is free. If the FIFO
// head has waited STARVE_MAX cycles, the pipeline is stalled for one cycle so
// the head can drain.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   p_i_commit/RegWr/rd/busW     pipeline write-back slot
//   l_i_issue, l_i_issue_rd      LLU accepted an op (marks rd pending)
//   l_i_valid/rd/data, l_o_ready LLU result handshake
//   q_i_rs1/2, q_o_rs1/2_busy    hazard queries against the pending scoreboard
//   o_RegWr/o_rd/o_busW/o_src    GPR write port (src 0 = pipeline, 1 = LLU)
//   o_stall_req                  pipeline must hold its WB inputs this cycle
//
// Handshake: an LLU result transfers in any cycle where l_i_valid and l_o_ready
// are both high. l_o_ready depends only on registered occupancy, never on
// l_i_valid, and the producer keeps l_i_valid/l_i_rd/l_i_data stable until the
// transfer completes.
module wb_arb_ysyx_23060136 #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_i_commit,
  input  logic        p_i_RegWr,
  input  logic [4:0]  p_i_rd,
  input  logic [31:0] p_i_busW,
  input  logic        l_i_issue,
  input  logic [4:0]  l_i_issue_rd,
  input  logic        l_i_valid,
  input  logic [4:0]  l_i_rd,
  input  logic [31:0] l_i_data,
  output logic        l_o_ready,
  input  logic [4:0]  q_i_rs1,
  input  logic [4:0]  q_i_rs2,
  output logic        q_o_rs1_busy,
  output logic        q_o_rs2_busy,
  output logic        o_RegWr,
  output logic [4:0]  o_rd,
  output logic [31:0] o_busW,
  output logic        o_src,
  output logic        o_stall_req
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic [31:1]   r_pending;

  logic          w_empty;
  logic          w_full;
  logic          w_preq;
  logic          w_stall;
  logic          w_pop;
  logic          w_pipe_wr;
  logic          w_push;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:1]   w_pending_nxt;
  logic [31:0]   w_pend_ext;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_head_rd   = r_fifo_rd[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // Writes to x0 are architecturally void, so they do not claim the slot.
  assign w_preq    = p_i_commit & p_i_RegWr & (p_i_rd != 5'd0);
  assign w_stall   = !rst & !w_empty & (r_starve == SW'(STARVE_MAX));
  assign w_pop     = !rst & !w_empty & (w_stall | !w_preq);
  assign w_pipe_wr = !rst & !w_stall & w_preq;

  // Ready from registered occupancy only: a full FIFO refuses even when it pops.
  assign l_o_ready = !rst & !w_full;
  // Results for x0 complete the handshake but are never buffered.
  assign w_push    = l_i_valid & l_o_ready & (l_i_rd != 5'd0);

  // Write-port mux. Idle cycles drive zeros so the port is quiet.
  always_comb begin
    o_RegWr = 1'b0;
    o_rd    = 5'd0;
    o_busW  = 32'd0;
    o_src   = 1'b0;
    if (w_pop) begin
      o_RegWr = 1'b1;
      o_rd    = w_head_rd;
      o_busW  = w_head_data;
      o_src   = 1'b1;
    end else if (w_pipe_wr) begin
      o_RegWr = 1'b1;
      o_rd    = p_i_rd;
      o_busW  = p_i_busW;
    end
  end

  assign o_stall_req = w_stall;

  // Scoreboard update: a new issue to the same rd overrides a same-cycle clear.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 1; i < 32; i++) begin
      if (w_pop && (w_head_rd == 5'(i))) w_pending_nxt[i] = 1'b0;
      if (l_i_issue && (l_i_issue_rd == 5'(i))) w_pending_nxt[i] = 1'b1;
    end
  end

  // Bit 0 tied low so a query for x0 is never busy.
  assign w_pend_ext   = {r_pending, 1'b0};
  assign q_o_rs1_busy = !rst & w_pend_ext[q_i_rs1];
  assign q_o_rs2_busy = !rst & w_pend_ext[q_i_rs2];

  // Buffer storage holds no control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= l_i_rd;
      r_fifo_data[r_wptr] <= l_i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // Counts cycles the current head has waited; a new head starts at zero.
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_MAX)) begin
        r_starve <= r_starve + 1'b1;
      end
      r_pending <= w_pending_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arb_ysyx_23060136.sv
// tb_wb_arb_ysyx_23060136
// Bench for the GPR write-port arbiter. A queue-based reference model predicts,
// for every cycle, the control outputs and the register-file write; a monitor on
// the falling edge pops and compares those predictions against the DUT.
module tb_wb_arb_ysyx_23060136;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_i_commit = 1'b0, p_i_RegWr = 1'b0;
  logic [4:0]  p_i_rd = '0;
  logic [31:0] p_i_busW = '0;
  logic        l_i_issue = 1'b0;
  logic [4:0]  l_i_issue_rd = '0;
  logic        l_i_valid = 1'b0;
  logic [4:0]  l_i_rd = '0;
  logic [31:0] l_i_data = '0;
  logic [4:0]  q_i_rs1 = '0, q_i_rs2 = '0;
  logic        l_o_ready, q_o_rs1_busy, q_o_rs2_busy;
  logic        o_RegWr, o_src, o_stall_req;
  logic [4:0]  o_rd;
  logic [31:0] o_busW;

  always #5 clk = ~clk;

  wb_arb_ysyx_23060136 #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .p_i_commit(p_i_commit), .p_i_RegWr(p_i_RegWr), .p_i_rd(p_i_rd), .p_i_busW(p_i_busW),
    .l_i_issue(l_i_issue), .l_i_issue_rd(l_i_issue_rd),
    .l_i_valid(l_i_valid), .l_i_rd(l_i_rd), .l_i_data(l_i_data), .l_o_ready(l_o_ready),
    .q_i_rs1(q_i_rs1), .q_i_rs2(q_i_rs2),
    .q_o_rs1_busy(q_o_rs1_busy), .q_o_rs2_busy(q_o_rs2_busy),
    .o_RegWr(o_RegWr), .o_rd(o_rd), .o_busW(o_busW), .o_src(o_src),
    .o_stall_req(o_stall_req)
  );

  // ---------------- scoreboard ----------------
  logic [37:0] exp_q[$];  // expected write {src, rd, data}
  logic [3:0]  ctl_q[$];  // expected {ready, stall, busy1, busy2}
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [36:0] mq[$];     // buffered LLU results {rd, data}, head at index 0
  int          wait_c = 0; // cycles the current head has gone unwritten
  bit [31:0]   pend = '0;
  bit          m_stall = 1'b0;
  bit          m_rdy = 1'b0;
  logic [4:0]  outst[$];  // issued ops whose result has not yet been handed over

  task automatic model_eval();
    logic [36:0] e;
    bit preq, popped, was_empty, b1, b2;
    if (rst) begin
      ctl_q.push_back(4'b0000);
      mq.delete();
      wait_c  = 0;
      pend    = '0;
      m_stall = 1'b0;
      m_rdy   = 1'b0;
      return;
    end
    m_rdy   = (mq.size() < DEPTH);
    m_stall = (mq.size() > 0) && (wait_c == SMAX);
    b1 = (q_i_rs1 != 0) && pend[q_i_rs1];
    b2 = (q_i_rs2 != 0) && pend[q_i_rs2];
    ctl_q.push_back({m_rdy, m_stall, b1, b2});
    preq      = p_i_commit && p_i_RegWr && (p_i_rd != 0);
    was_empty = (mq.size() == 0);
    popped    = 1'b0;
    if (m_stall || (!preq && !was_empty)) begin
      e = mq.pop_front();
      exp_q.push_back({1'b1, e});
      pend[e[36:32]] = 1'b0;
      popped = 1'b1;
    end else if (preq) begin
      exp_q.push_back({1'b0, p_i_rd, p_i_busW});
    end
    if (popped || was_empty) wait_c = 0;
    else if (wait_c < SMAX) wait_c++;
    if (l_i_valid && m_rdy && (l_i_rd != 0)) mq.push_back({l_i_rd, l_i_data});
    if (l_i_issue && (l_i_issue_rd != 0)) pend[l_i_issue_rd] = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [37:0] w;
      if (ctl_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL ctl: no expectation queued (t=%0t)", $time);
      end else begin
        chk("ctl {ready,stall,busy1,busy2}",
            {36'b0, l_o_ready, o_stall_req, q_o_rs1_busy, q_o_rs2_busy}, {36'b0, ctl_q.pop_front()});
      end
      if (o_RegWr) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected write: got %h, want none (t=%0t)", {o_src, o_rd, o_busW}, $time);
        end else begin
          chk("write {src,rd,data}", {2'b0, o_src, o_rd, o_busW}, {2'b0, exp_q.pop_front()});
        end
      end else begin
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          n_cmp++; n_err++;
          $display("FAIL missing write: got none, want %h (t=%0t)", w, $time);
        end
        chk("idle outputs {src,rd,data}", {2'b0, o_src, o_rd, o_busW}, 40'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input bit on, input logic [4:0] rd, input logic [31:0] d);
    p_i_commit = on;
    p_i_RegWr  = on;
    p_i_rd     = rd;
    p_i_busW   = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    l_i_issue = 1'b1; l_i_issue_rd = rd;
    step();
    l_i_issue = 1'b0;
  endtask

  task automatic llu(input bit v, input logic [4:0] rd, input logic [31:0] d);
    l_i_valid = v; l_i_rd = rd; l_i_data = d;
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] items [3];
  int         idx;
  logic [4:0] r;

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held two cycles, then idle state.
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    q_i_rs1 = 5'd5;
    #1;
    chk("reset ready", {39'b0, l_o_ready}, 40'd1);
    chk("reset regwr/stall/busy", {37'b0, o_RegWr, o_stall_req, q_o_rs1_busy}, 40'd0);
    step();

    // Idle LLU write of 0xDEADBEEF to x5.
    issue(5'd5);
    llu(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("busy x5 while pending", {39'b0, q_o_rs1_busy}, 40'd1);
    step();
    llu(1'b0, 5'd0, 32'd0);
    #1;
    chk("idle LLU write", {1'b0, o_RegWr, o_src, o_rd, o_busW}, {1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF});
    step();
    #1;
    chk("x5 free after write", {39'b0, q_o_rs1_busy}, 40'd0);
    step();

    // Starvation: pipeline writes x3 every cycle, LLU result for x7 pushed at t.
    issue(5'd7);
    pipe(1'b1, 5'd3, 32'h11);
    llu(1'b1, 5'd7, 32'h77);
    step();
    llu(1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= SMAX; k++) begin
      #1;
      chk("pipeline wins while head waits", {33'b0, o_RegWr, o_src, o_rd}, {33'b0, 1'b1, 1'b0, 5'd3});
      step();
    end
    #1;
    chk("forced stall drains head", {32'b0, o_stall_req, o_src, o_rd, o_RegWr}, {32'b0, 1'b1, 1'b1, 5'd7, 1'b1});
    step();
    #1;
    chk("pipeline resumes", {32'b0, o_stall_req, o_src, o_rd, o_RegWr}, {32'b0, 1'b0, 1'b0, 5'd3, 1'b1});
    step();

    // Full FIFO: three back-to-back results while the pipeline keeps writing.
    items[0] = 5'd10; items[1] = 5'd11; items[2] = 5'd12;
    issue(items[0]); issue(items[1]); issue(items[2]);
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      if (idx < 3) llu(1'b1, items[idx], 32'hA000_0000 + 32'(idx));
      else         llu(1'b0, 5'd0, 32'd0);
      if (k == 2) begin
        #1;
        chk("third result refused while full", {39'b0, l_o_ready}, 40'd0);
      end
      step();
      if (l_i_valid && m_rdy) idx++;
    end
    llu(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 4; k++) step();

    // x0: a pipeline write to x0 leaves the slot to the FIFO head.
    issue(5'd20);
    pipe(1'b1, 5'd3, 32'h33);
    llu(1'b1, 5'd20, 32'h2020_2020);
    step();
    llu(1'b0, 5'd0, 32'd0);
    pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("x0 pipeline yields to head", {33'b0, o_RegWr, o_src, o_rd}, {33'b0, 1'b1, 1'b1, 5'd20});
    step();
    // x0: an LLU result for x0 is accepted but never written.
    pipe(1'b0, 5'd0, 32'd0);
    llu(1'b1, 5'd0, 32'h0BAD_0BAD);
    #1;
    chk("x0 result accepted", {39'b0, l_o_ready}, 40'd1);
    step();
    llu(1'b0, 5'd0, 32'd0);
    step(); step();

    // Reset with two buffered entries and x5/x9 pending.
    issue(5'd5); issue(5'd9);
    pipe(1'b1, 5'd3, 32'h44);
    llu(1'b1, 5'd5, 32'h5555_5555); step();
    llu(1'b1, 5'd9, 32'h9999_9999); step();
    llu(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    q_i_rs1 = 5'd5; q_i_rs2 = 5'd9;
    #1;
    chk("post-reset busy x5/x9 and ready", {37'b0, q_o_rs1_busy, q_o_rs2_busy, l_o_ready}, 40'd1);
    for (int k = 0; k < 8; k++) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!m_stall) begin
        p_i_commit = ($urandom_range(0, 9) < 6);
        p_i_RegWr  = ($urandom_range(0, 3) != 0);
        p_i_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        p_i_busW   = $urandom;
      end
      if (!l_i_valid) begin
        if (outst.size() > 0 && $urandom_range(0, 2) == 0) llu(1'b1, outst[0], $urandom);
        else if ($urandom_range(0, 29) == 0)                llu(1'b1, 5'd0, $urandom);
      end
      l_i_issue = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        r = 5'($urandom_range(1, 31));
        if (!pend[r]) begin
          l_i_issue = 1'b1;
          l_i_issue_rd = r;
        end
      end
      q_i_rs1 = 5'($urandom);
      q_i_rs2 = 5'($urandom);
      step();
      if (rst) begin
        outst.delete();
        llu(1'b0, 5'd0, 32'd0);
      end else begin
        if (l_i_valid && m_rdy) begin
          if (l_i_rd != 0) void'(outst.pop_front());
          llu(1'b0, 5'd0, 32'd0);
        end
        if (l_i_issue) outst.push_back(l_i_issue_rd);
      end
    end
    rst = 1'b0;
    l_i_issue = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    llu(1'b0, 5'd0, 32'd0);
    for (int k = 0; k < 8; k++) step();

    mon_en = 1'b0;
    chk("leftover expected writes", 40'(exp_q.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
